regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port register file for the multicycle datapath, generalising the fixed 8×16 three-address file. It keeps two combinational read ports and adds a second write port, optional write-to-read bypass, an optional hardwired-zero register 0 and a per-register pending scoreboard. The scoreboard lets the control FSM reserve a destination register and stall on reads of registers whose write is still outstanding.

## Interface
- WIDTH, 16, data width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations
- BYPASS, 1, when 1, a read of an address being written this cycle returns the write data

- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high; clears all registers and pending bits
- a1  in  ADDR_W  read port 1 address
- a2  in  ADDR_W  read port 2 address
- rd1  out  WIDTH  read port 1 data
- rd2  out  WIDTH  read port 2 data
- we3  in  1  write port 3 enable
- a3  in  ADDR_W  write port 3 address
- wd3  in  WIDTH  write port 3 data
- we4  in  1  write port 4 enable; has priority over port 3
- a4  in  ADDR_W  write port 4 address
- wd4  in  WIDTH  write port 4 data
- rsv  in  1  reserve request: marks register ra pending
- ra  in  ADDR_W  register to reserve
- busy1  out  1  pending flag for a1
- busy2  out  1  pending flag for a2

## Operation
- State: mem[DEPTH] of WIDTH bits and pending[DEPTH] of 1 bit.
- Reset (asynchronous, while reset=1):
  - all mem and pending are 0
  - rd1 = rd2 = 0; bypass is suppressed
  - busy1 = busy2 = 0
  - writes and reservations are ignored
- Writes, on rising clk edge:
  - if we3, mem[a3] <= wd3
  - if we4, mem[a4] <= wd4
  - if both are enabled with a3 == a4, port 4 wins and wd3 is discarded
- With ZERO_REG=1, a write to address 0 is a no-op.
- Read data rdN, combinational, evaluated in this order:
  1. ZERO_REG and aN==0: output 0
  2. BYPASS, we4 and a4==aN: output wd4
  3. BYPASS, we3 and a3==aN: output wd3
  4. otherwise: output mem[aN]
- Scoreboard, on rising clk edge:
  - a write by either port clears pending[addr]
  - rsv sets pending[ra]
  - if the same register is written and reserved in one cycle, set wins, because the reservation belongs to a newer producer
  - with ZERO_REG=1, rsv with ra==0 is ignored
- busyN = pending[aN], forced to 0 in each of these cases:
  - ZERO_REG and aN==0
  - BYPASS and aN matches an enabled write this cycle, since the data is being forwarded
- Reserving an already-pending register leaves it pending; this is not an error.
- An unreserved write to a pending register clears its pending bit; a write does not need a prior reservation.

## Timing
- Write latency: 1 edge. Data is visible on rd from the cycle after the edge, or in the same cycle when BYPASS=1.
- With BYPASS=0, a same-cycle read of a register being written returns the old contents.
- Read ports and busy flags are purely combinational from addresses, write inputs and state; they are not registered.
- pending changes only at clk edges or on reset. A reservation made at edge N is reflected on busy from edge N onward.
- Asserting reset mid-operation clears state immediately, without waiting for a clock. On reset deassertion, the first write or reservation takes effect at the next rising edge.
- Port widths track WIDTH and ADDR_W exactly; there is no truncation or extension inside the block.

## Test plan
- Reset and zero register, defaults:
  - assert reset with we3=1, a3=1, wd3=16'hffff → rd1=rd2=0 and busy1=busy2=0 throughout reset
  - after release, write 16'h1234 to address 0 → reading address 0 returns 0
- Basic write/read:
  - write 16'habcd to r1, then 16'h0123 to r2 on successive edges
  - next cycle, a1=1, a2=2 → rd1=16'habcd, rd2=16'h0123
- Dual-write conflict: we3=we4=1, a3=a4=3, wd3=16'hcccc, wd4=16'h3333 → after the edge, rd of r3 is 16'h3333
- Bypass:
  - BYPASS=1: a1=5 with we3=1, a3=5, wd3=16'h5a5a → rd1=16'h5a5a in the same cycle
  - BYPASS=0 build, same stimulus → rd1 shows the old value (0) until after the edge
- Scoreboard:
  - rsv=1, ra=4 at an edge → busy1=1 with a1=4
  - we4=1, a4=4, wd4=16'h00ff at a later edge → busy1 is 0 in that cycle (BYPASS=1) and 0 after the edge
  - rsv with ra=4 and a same-cycle write to 4 → busy1 stays 1 after the edge
- Reset mid-operation: with pending[4]=1 and r1=16'habcd, pulse reset between edges → rd1=0 and busy1=0 immediately, and both stay cleared after release

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, two write
// ports (port 4 has priority), optional write-to-read bypass, optional
// hardwired-zero register 0 and a per-register pending scoreboard.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] a4,
  input  logic [WIDTH-1:0]  wd4,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] ra,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;

  logic              wr3Ok;
  logic              wr4Ok;
  logic              rsvOk;

  logic [ADDR_W-1:0] rAddr [2];
  logic [WIDTH-1:0]  rData [2];
  logic              rBusy [2];

  // Writes and reservations aimed at the hardwired zero register are dropped.
  assign wr3Ok = we3 && !(ZERO_REG && (a3 == '0));
  assign wr4Ok = we4 && !(ZERO_REG && (a4 == '0));
  assign rsvOk = rsv && !(ZERO_REG && (ra == '0));

  // Port 4 is applied after port 3 so it wins an address clash; the
  // reservation is applied last because it belongs to a newer producer.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    if (wr3Ok) begin
      mem_d[a3]     = wd3;
      pending_d[a3] = 1'b0;
    end
    if (wr4Ok) begin
      mem_d[a4]     = wd4;
      pending_d[a4] = 1'b0;
    end
    if (rsvOk) begin
      pending_d[ra] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  assign rAddr[0] = a1;
  assign rAddr[1] = a2;

  // Both read ports share one priority chain: zero register, then forwarded
  // write data (port 4 before port 3), then stored contents. A forwarded
  // register is not reported busy since its value is already on the port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rData[p] = mem_q[rAddr[p]];
      rBusy[p] = pending_q[rAddr[p]];
      if (reset) begin
        rData[p] = '0;
        rBusy[p] = 1'b0;
      end else if (ZERO_REG && (rAddr[p] == '0)) begin
        rData[p] = '0;
        rBusy[p] = 1'b0;
      end else if (BYPASS && we4 && (a4 == rAddr[p])) begin
        rData[p] = wd4;
        rBusy[p] = 1'b0;
      end else if (BYPASS && we3 && (a3 == rAddr[p])) begin
        rData[p] = wd3;
        rBusy[p] = 1'b0;
      end
    end
  end

  assign rd1   = rData[0];
  assign rd2   = rData[1];
  assign busy1 = rBusy[0];
  assign busy2 = rBusy[1];

endmodule
